// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- instruction memory bus between the fetch stage and memory.
//
// Signals:
//   imem_req   fetch -> mem   request strobe, held until imem_ack
//   imem_addr  fetch -> mem   word-aligned fetch address, stable while pending
//   imem_ack   mem -> fetch   response strobe; imem_rdata valid in that cycle
//   imem_rdata mem -> fetch   fetched instruction word
//
// Modports:
//   master  fetch stage side (drives request/address)
//   slave   memory side (drives ack/data)
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Fetches sequential words from instruction memory over a req/ack bus, one
// instruction per acknowledged cycle, and presents them to decode through a
// registered IF/ID stage. A one-entry hold buffer absorbs a response that
// arrives while decode is stalled on an occupied IF/ID register. Redirects
// from execute flush IF/ID and the hold buffer; a response still in flight
// for the old path is drained and dropped before fetching the new target.
//
// Ports:
//   clk          clock, rising-edge
//   rst_n        asynchronous active-low reset
//   bus          instruction memory bus (if_stage_if.master)
//   stall        decode cannot accept; IF/ID outputs are held
//   redirect     taken branch / flush from execute (highest priority)
//   redirect_pc  new fetch target, bits [1:0] ignored
//   id_valid     IF/ID register holds a valid instruction
//   id_instr     registered instruction word
//   id_pc4       address of id_instr plus 4
//   id_opcode    id_instr[31:26], combinational, to decode control
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    if_stage_if.master         bus,
    input  logic               stall,
    input  logic               redirect,
    input  logic        [31:0] redirect_pc,
    output logic               id_valid,
    output logic        [31:0] id_instr,
    output logic        [31:0] id_pc4,
    output logic        [5:0]  id_opcode
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Fetch-side state (p0): program counter, address of a response being
    // drained after a redirect, and the one-entry hold buffer.
    logic [31:0] pc_p0, pc_nxt;
    logic [31:0] disc_addr_p0, disc_addr_nxt;
    logic [31:0] hold_instr_p0, hold_pc4_p0;
    logic        hold_load;

    // IF/ID register (p1).
    logic        vld_p1, vld_nxt;
    logic [31:0] instr_p1, instr_nxt;
    logic [31:0] pc4_p1, pc4_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic        can_load;

    assign pc_plus4     = pc_p0 + 32'd4;   // wraps modulo 2^32
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign can_load     = !vld_p1 || !stall;

    // The reset term keeps the request low while rst_n is asserted even
    // though the state register already sits in FETCH.
    assign bus.imem_req  = rst_n && (state != HOLD);
    // DISCARD keeps presenting the abandoned address until its ack arrives,
    // while pc_p0 already points at the redirect target.
    assign bus.imem_addr = (state == DISCARD) ? disc_addr_p0 : pc_p0;

    assign id_valid  = vld_p1;
    assign id_instr  = instr_p1;
    assign id_pc4    = pc4_p1;
    assign id_opcode = instr_p1[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_p0;
        disc_addr_nxt = disc_addr_p0;
        hold_load     = 1'b0;
        // An accepted instruction leaves IF/ID unless something new loads.
        vld_nxt       = vld_p1 && stall;
        instr_nxt     = instr_p1;
        pc4_nxt       = pc4_p1;

        if (redirect) begin
            vld_nxt = 1'b0;
            pc_nxt  = redirect_tgt;
            unique case (state)
                FETCH: begin
                    if (!bus.imem_ack) begin
                        state_nxt     = DISCARD;
                        disc_addr_nxt = pc_p0;
                    end
                end
                HOLD: begin
                    state_nxt = FETCH;
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        pc_nxt = pc_plus4;
                        if (can_load) begin
                            vld_nxt   = 1'b1;
                            instr_nxt = bus.imem_rdata;
                            pc4_nxt   = pc_plus4;
                        end else begin
                            hold_load = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        vld_nxt   = 1'b1;
                        instr_nxt = hold_instr_p0;
                        pc4_nxt   = hold_pc4_p0;
                        state_nxt = FETCH;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    // Stage p0 -> p1 boundary: fetch state and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0        <= RESET_PC_ALIGNED;
            disc_addr_p0 <= RESET_PC_ALIGNED;
            vld_p1       <= 1'b0;
            instr_p1     <= 32'd0;
            pc4_p1       <= 32'd0;
        end else begin
            pc_p0        <= pc_nxt;
            disc_addr_p0 <= disc_addr_nxt;
            vld_p1       <= vld_nxt;
            instr_p1     <= instr_nxt;
            pc4_p1       <= pc4_nxt;
        end
    end

    // Hold buffer payload; its validity is implied by state == HOLD.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_instr_p0 <= bus.imem_rdata;
            hold_pc4_p0   <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_opcode   (id_opcode)
    );

    int unsigned n_cmp;
    int unsigned n_fail;
    logic [31:0] salt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Instruction memory contents: a fixed hash of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ salt;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b want=0", bus.imem_req); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", id_valid); end
        n_cmp++; if (id_instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr got=%h want=0", id_instr); end
        n_cmp++; if (id_pc4 !== 32'd0) begin n_fail++; $display("FAIL rst_pc4 got=%h want=0", id_pc4); end
        n_cmp++; if (id_opcode !== 6'd0) begin n_fail++; $display("FAIL rst_opcode got=%h want=0", id_opcode); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got=%b want=1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rel_addr got=%h want=%h", bus.imem_addr, RESET_PC); end
    endtask

    // Ack every cycle, no stall: one instruction per cycle, ID one behind.
    task automatic test_sequential();
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            #1;
            n_cmp++; if (bus.imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr k=%0d got=%h want=%h", k, bus.imem_addr, 32'(4 * k)); end
            if (k > 0) begin
                w = mem_word(32'(4 * (k - 1)));
                n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid k=%0d got=%b want=1", k, id_valid); end
                n_cmp++; if (id_pc4 !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc4 k=%0d got=%h want=%h", k, id_pc4, 32'(4 * k)); end
                n_cmp++; if (id_instr !== w) begin n_fail++; $display("FAIL seq_instr k=%0d got=%h want=%h", k, id_instr, w); end
                n_cmp++; if (id_opcode !== w[31:26]) begin n_fail++; $display("FAIL seq_opcode k=%0d got=%h want=%h", k, id_opcode, w[31:26]); end
            end
            tick();
        end
    endtask

    // Three-cycle ack latency: address held, one-cycle id_valid pulses.
    task automatic test_latency();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) begin
                bus.imem_ack   = (c == 2);
                bus.imem_rdata = mem_word(bus.imem_addr);
                #1;
                n_cmp++; if (bus.imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL lat_addr i=%0d c=%0d got=%h want=%h", i, c, bus.imem_addr, 32'(4 * i)); end
                n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL lat_req i=%0d c=%0d got=%b want=1", i, c, bus.imem_req); end
                if (i > 0 && c == 0) begin
                    w = mem_word(32'(4 * (i - 1)));
                    n_cmp++; if (id_valid !== 1'b1 || id_instr !== w) begin n_fail++; $display("FAIL lat_word i=%0d got=%b/%h want=1/%h", i, id_valid, id_instr, w); end
                end else begin
                    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pulse i=%0d c=%0d got=%b want=0", i, c, id_valid); end
                end
                tick();
            end
        end
    endtask

    // Stall with an occupied ID register while word@8 is acked.
    task automatic test_stall_hold();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            stall          = (k == 2);
            tick();
        end
        bus.imem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req c=%0d got=%b want=0", c, bus.imem_req); end
            n_cmp++; if (id_valid !== 1'b1 || id_instr !== mem_word(32'd4) || id_pc4 !== 32'd8) begin n_fail++; $display("FAIL hold_id c=%0d got=%b/%h/%h want=1/%h/8", c, id_valid, id_instr, id_pc4, mem_word(32'd4)); end
            tick();
        end
        stall = 1'b0;
        tick();
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== mem_word(32'd8) || id_pc4 !== 32'd12) begin n_fail++; $display("FAIL hold_release got=%b/%h/%h want=1/%h/c", id_valid, id_instr, id_pc4, mem_word(32'd8)); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd12) begin n_fail++; $display("FAIL hold_resume got=%b/%h want=1/c", bus.imem_req, bus.imem_addr); end
    endtask

    // Redirect while the request to 0x10 is outstanding.
    task automatic test_redirect_pending();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            tick();
        end
        bus.imem_ack = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 32'h0000_0103;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL rdp_addr0 got=%h want=10", bus.imem_addr); end
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_flush got=%b want=0", id_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL rdp_drain got=%b/%h want=1/10", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(32'h10);
        tick();
        bus.imem_rdata = mem_word(bus.imem_addr);
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_dropped got=%b want=0", id_valid); end
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rdp_target got=%h want=100", bus.imem_addr); end
        tick();
        bus.imem_ack = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== mem_word(32'h100) || id_pc4 !== 32'h104) begin n_fail++; $display("FAIL rdp_first got=%b/%h/%h want=1/%h/104", id_valid, id_instr, id_pc4, mem_word(32'h100)); end
    endtask

    // Redirect coinciding with an ack while decode stalls.
    task automatic test_redirect_ack_stall();
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        tick();
        bus.imem_rdata = mem_word(bus.imem_addr);
        stall          = 1'b1;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        idle_inputs();
        stall = 1'b1;
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ras_valid got=%b want=0", id_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL ras_addr got=%b/%h want=1/200", bus.imem_req, bus.imem_addr); end
    endtask

    // PC wrap at the top of the address space, then reset mid-wait.
    task automatic test_wrap_reset();
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        redirect       = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%h want=fffffffc", bus.imem_addr); end
        bus.imem_rdata = mem_word(32'hFFFF_FFFC);
        tick();
        bus.imem_ack = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_pc4 !== 32'd0 || id_instr !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_id got=%b/%h/%h want=1/0/%h", id_valid, id_pc4, id_instr, mem_word(32'hFFFF_FFFC)); end
        n_cmp++; if (bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_next got=%h want=0", bus.imem_addr); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst got=%b/%b want=0/0", bus.imem_req, id_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst_restart got=%b/%h want=1/%h", bus.imem_req, bus.imem_addr, RESET_PC); end
    endtask

    // Random stall/redirect/latency against a program-order model: every
    // instruction decode accepts must be the next word on the current path.
    task automatic test_random();
        logic [31:0] exp_addr;
        logic        outstanding;
        logic [31:0] oaddr;
        int unsigned lat, cnt, delivered;
        logic        was_redirect, was_hold;
        logic [31:0] prev_instr, prev_pc4;
        do_reset();
        exp_addr    = RESET_PC;
        outstanding = 1'b0;
        oaddr       = 32'd0;
        lat         = 0;
        cnt         = 0;
        delivered   = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            stall       = ($urandom_range(3) == 0);
            redirect    = ($urandom_range(19) == 0);
            redirect_pc = $urandom;
            bus.imem_ack = 1'b0;
            if (bus.imem_req) begin
                if (!outstanding) begin
                    outstanding = 1'b1;
                    oaddr       = bus.imem_addr;
                    lat         = $urandom_range(3);
                    cnt         = 0;
                end else begin
                    n_cmp++; if (bus.imem_addr !== oaddr) begin n_fail++; $display("FAIL rnd_addr_stable cyc=%0d got=%h want=%h", cyc, bus.imem_addr, oaddr); end
                end
                bus.imem_ack = (cnt == lat);
            end
            bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : $urandom;
            #1;
            if (id_valid && !stall) begin
                n_cmp++; if (id_instr !== mem_word(exp_addr) || id_pc4 !== exp_addr + 32'd4) begin n_fail++; $display("FAIL rnd_order cyc=%0d got=%h/%h want=%h/%h", cyc, id_instr, id_pc4, mem_word(exp_addr), exp_addr + 32'd4); end
                exp_addr  = exp_addr + 32'd4;
                delivered++;
            end
            was_redirect = redirect;
            was_hold     = id_valid && stall && !redirect;
            prev_instr   = id_instr;
            prev_pc4     = id_pc4;
            if (redirect) exp_addr = redirect_pc & 32'hFFFF_FFFC;
            if (bus.imem_ack) outstanding = 1'b0;
            else if (outstanding) cnt++;
            tick();
            if (was_redirect) begin
                n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush cyc=%0d got=%b want=0", cyc, id_valid); end
            end
            if (was_hold) begin
                n_cmp++; if (id_valid !== 1'b1 || id_instr !== prev_instr || id_pc4 !== prev_pc4) begin n_fail++; $display("FAIL rnd_stall_hold cyc=%0d got=%b/%h/%h want=1/%h/%h", cyc, id_valid, id_instr, id_pc4, prev_instr, prev_pc4); end
            end
        end
        n_cmp++; if (delivered < 100) begin n_fail++; $display("FAIL rnd_progress got=%0d want>=100", delivered); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        salt   = $urandom | 32'h0000_0001;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_latency();
        test_stall_hold();
        test_redirect_pending();
        test_redirect_ack_stall();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset; bits [1:0] SHALL be treated as zero.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req  output  1  instruction memory request.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  decode cannot accept; id_* SHALL be held.
REQ-009 redirect  input  1  taken branch/flush from execute.
REQ-010 redirect_pc  input  32  new fetch target; bits [1:0] ignored.
REQ-011 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 id_instr  output  32  registered instruction.
REQ-013 id_pc4  output  32  address of id_instr plus 4.
REQ-014 id_opcode  output  6  id_instr[31:26], combinational, feeds the decode control unit.

Function
REQ-015 States: FETCH, HOLD, DISCARD; imem_req SHALL be 1 in FETCH and DISCARD, 0 in HOLD.
REQ-016 imem_addr SHALL equal pc in FETCH and SHALL stay constant from request until imem_ack; imem_ack may arrive in the first request cycle or any later cycle.
REQ-017 Transfer condition: IF/ID register can load when id_valid=0 or stall=0.
REQ-018 FETCH, imem_ack=1, can load: id_instr<=imem_rdata, id_pc4<=pc+4, id_valid<=1, pc<=pc+4, remain FETCH (back-to-back fetch, one instruction per acked cycle).
REQ-019 FETCH, imem_ack=1, cannot load: capture imem_rdata and pc+4 in a one-entry hold buffer, pc<=pc+4, go HOLD.
REQ-020 HOLD, stall=0: hold buffer moves to IF/ID register (id_valid<=1), go FETCH; stall=1: remain HOLD, nothing changes.
REQ-021 id_valid=1, stall=0, no new instruction loaded that cycle: id_valid<=0; id_instr/id_pc4 keep their values.
REQ-022 redirect=1 has priority over all other events: id_valid<=0, hold buffer discarded, pc<={redirect_pc[31:2],2'b00}.
REQ-023 redirect=1 in FETCH with no imem_ack that cycle: go DISCARD; DISCARD keeps old imem_addr until imem_ack, drops that response, then goes FETCH at the redirected pc.
REQ-024 redirect=1 with imem_ack=1 the same cycle, or in HOLD: response/buffer dropped, go FETCH next cycle at redirect_pc.
REQ-025 redirect=1 in DISCARD: pc updated to the newest redirect_pc; state stays DISCARD until the pending ack.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 redirect asserted during stall SHALL still flush id_valid to 0 at the next edge.

Reset
REQ-028 While rst_n=0: imem_req=0, pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc4=0, hold buffer invalid.
REQ-029 Reset assertion mid-transaction SHALL abandon any outstanding request; first request after release SHALL use RESET_PC in the first cycle with rst_n=1.

Verification
REQ-030 Reset release, imem_ack=1 every cycle, stall=0 -> imem_addr 0,4,8,...; id_pc4 4,8,12 one cycle behind; id_opcode=imem_rdata[31:26].
REQ-031 Ack latency 3 cycles -> imem_addr held 3 cycles, id_valid pulses 1 cycle per instruction, no duplicate or lost words.
REQ-032 stall=1 with id_valid=1 and ack on addr 8 -> state HOLD, imem_req=0, id_instr unchanged; stall=0 -> word@8 appears next cycle, fetch resumes at 12.
REQ-033 redirect=1, redirect_pc=32'h0000_0103 while request to 0x10 pending -> response for 0x10 dropped, next request addr 32'h0000_0100, id_valid=0 meanwhile.
REQ-034 redirect and imem_ack same cycle with stall=1 -> id_valid=0 next cycle, next imem_addr=redirect_pc.
REQ-035 pc=32'hFFFF_FFFC acked -> id_pc4=0, next imem_addr=0; rst_n pulsed low mid-wait -> imem_req=0 immediately, restart at RESET_PC.
